// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_HIGH
    } rx_state_t;

    localparam int DATA_BITS     = 8;
    localparam int RX_FIFO_DEPTH = 4;

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO holding received bytes; head is shown combinationally
// and reads as zero while empty.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = DATA_BITS,
    parameter int DEPTH = RX_FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             not_empty,
    output logic             full
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign not_empty = (count != '0);
    assign full      = (count == (PTR_W+1)'(DEPTH));
    assign do_pop    = pop && not_empty;
    // A pop in the same cycle frees the slot a full FIFO needs for the push.
    assign do_push   = push && (!full || do_pop);
    assign head      = not_empty ? mem[rd_ptr] : '0;

    // NOTE: storage is deliberately not reset; the count gates every read,
    // so stale contents are never visible and the array can map to plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with valid/ready output. Define UART_RX_FIFO_EN to buffer
// received bytes in a 4-entry FIFO instead of a single holding register.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLOCK_HZ = 27_000_000,
    parameter int BAUD     = 115_200
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 uart_rx_pin,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int DIVISOR = CLOCK_HZ / BAUD;
    localparam int CNT_W   = $clog2(DIVISOR);
    localparam int IDX_W   = $clog2(DATA_BITS);
    // Counters run down to zero, so a load of N-1 spans N cycles.
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(DIVISOR - 1);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(DIVISOR / 2 - 1);
    localparam logic [IDX_W-1:0] LAST_BIT  = IDX_W'(DATA_BITS - 1);

    if (DIVISOR < 4) begin : g_divisor_check
        $error("uart_rx: CLOCK_HZ/BAUD must be at least 4");
    end

    logic                 rx_meta;
    logic                 rx_s;
    rx_state_t            state;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shift;
    logic                 byte_done;
    logic                 pop;

    // NOTE: every sequential block uses non-blocking assignments so all flops
    // update together on the edge regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= uart_rx_pin;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        frame_err <= 1'b0;
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state <= ST_START;
                        cnt   <= HALF_LOAD;
                    end
                end
                ST_START: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (!rx_s) begin
                        state   <= ST_DATA;
                        cnt     <= FULL_LOAD;
                        bit_idx <= '0;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_DATA: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        shift <= {rx_s, shift[DATA_BITS-1:1]};
                        cnt   <= FULL_LOAD;
                        if (bit_idx == LAST_BIT) begin
                            state <= ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
                ST_STOP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (rx_s) begin
                        state <= ST_IDLE;
                    end else begin
                        frame_err <= 1'b1;
                        state     <= ST_WAIT_HIGH;
                    end
                end
                ST_WAIT_HIGH: begin
                    if (rx_s) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign byte_done = (state == ST_STOP) && (cnt == '0) && rx_s;
    assign pop       = rx_valid && rx_ready;

`ifdef UART_RX_FIFO_EN
    logic fifo_full;

    uart_rx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (RX_FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (byte_done),
        .push_data (shift),
        .pop       (pop),
        .head      (rx_data),
        .not_empty (rx_valid),
        .full      (fifo_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            overrun <= 1'b0;
        end else begin
            overrun <= byte_done && fifo_full && !pop;
        end
    end
`else
    logic [DATA_BITS-1:0] hold_data;
    logic                 hold_valid;

    always_ff @(posedge clk) begin
        overrun <= 1'b0;
        if (rst) begin
            hold_data  <= '0;
            hold_valid <= 1'b0;
        end else if (byte_done) begin
            // A transfer in the completion cycle frees the register for the new byte.
            if (!hold_valid || pop) begin
                hold_data  <= shift;
                hold_valid <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end else if (pop) begin
            hold_valid <= 1'b0;
        end
    end

    assign rx_data  = hold_data;
    assign rx_valid = hold_valid;
`endif

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLOCK_HZ, default 27_000_000, meaning input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115_200, meaning line bit rate.
REQ-003 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port uart_rx_pin  input  1  asynchronous serial line, idle high.
REQ-006 SHALL have port rx_data  output  8  received byte, valid while rx_valid is high.
REQ-007 SHALL have port rx_valid  output  1  byte available.
REQ-008 SHALL have port rx_ready  input  1  consumer accepts; a transfer occurs on a cycle with rx_valid and rx_ready both high.
REQ-009 SHALL have port frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
REQ-010 SHALL have port overrun  output  1  one-cycle pulse when a completed byte is dropped.

Function
REQ-011 SHALL pass uart_rx_pin through a 2-flop synchronizer; all line decisions use the synchronized value.
REQ-012 SHALL use DIVISOR = CLOCK_HZ/BAUD (integer division); DIVISOR < 4 SHALL fail elaboration; bit counter width = $clog2(DIVISOR).
REQ-013 SHALL implement states IDLE, START, DATA, STOP, WAIT_HIGH; frame = 1 start, 8 data (LSB first), 1 stop, no parity.
REQ-014 IDLE: synchronized line low -> START, counter loaded for DIVISOR/2 cycles.
REQ-015 START: at half-bit expiry, line low -> DATA with counter DIVISOR; line high -> IDLE (glitch rejected, no output activity).
REQ-016 DATA: sample once per DIVISOR cycles into shift register, bit index 0..7; after bit 7 -> STOP.
REQ-017 STOP: after DIVISOR cycles, sample high -> byte complete, -> IDLE; sample low -> frame_err pulse, byte discarded, -> WAIT_HIGH.
REQ-018 WAIT_HIGH: remain until synchronized line high, then -> IDLE.
REQ-019 On byte complete, rx_valid and rx_data SHALL update on the cycle after the stop-bit sample.
REQ-020 rx_valid SHALL stay high and rx_data stable until a transfer.
REQ-021 Byte completes while storage is full and no transfer occurs in the same cycle -> new byte dropped, stored data kept, overrun pulses.
REQ-022 Byte completes in the same cycle as a transfer -> new byte stored, no overrun.
REQ-023 Back-to-back frames with no idle bit between stop and next start SHALL be received without loss.

Reset
REQ-024 On rst: state IDLE, counters 0, synchronizer flops 1, rx_data 0x00, rx_valid 0, frame_err 0, overrun 0, storage emptied.
REQ-025 rst asserted mid-frame SHALL abandon the frame; reception restarts at the next start bit after rst deasserts.

Configuration
REQ-026 Macro UART_RX_FIFO_EN defined: storage SHALL be a 4-entry FIFO; rx_data shows the head; overrun only when the FIFO is full with no pop that cycle.
REQ-027 UART_RX_FIFO_EN undefined: storage SHALL be a single holding register; behaviour per REQ-019..REQ-022 with depth 1.

Structure
REQ-028 Package uart_pkg SHALL hold the rx state enum typedef, DATA_BITS = 8 and RX_FIFO_DEPTH = 4.
REQ-029 The FIFO SHALL be sub-module uart_rx_fifo, instantiated only under UART_RX_FIFO_EN.

Verification (CLOCK_HZ=1_600_000, BAUD=100_000, DIVISOR=16)
REQ-030 Send 0xA5, rx_ready held high -> rx_valid high exactly 1 cycle with rx_data=0xA5; frame_err and overrun stay 0.
REQ-031 Line low for 4 cycles, then high -> no rx_valid, no frame_err; a following 0x5A is received correctly.
REQ-032 Send 0x3C with stop bit low, line held low 40 more cycles -> one frame_err pulse, no rx_valid; next 0x42 after line returns high is received.
REQ-033 rx_ready low, send 0x11 then 0x22 -> without macro: rx_data stays 0x11, one overrun pulse; with macro: 0x11 then 0x22 delivered in order once rx_ready rises, no overrun.
REQ-034 Back-to-back 0x00, 0xFF, 0x81 with no gaps, rx_ready high -> three transfers in order, no errors.
REQ-035 rst pulsed for 1 cycle during bit 3 of a frame -> all outputs at reset values; next full frame 0x7E is received correctly.
